// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Latency L+2 cycles (L = MUL_CYCLES or OTHER_CYCLES); one op in flight, stalls requests until its response is taken.
module alu_scheduler #(
  parameter int MUL_CYCLES   = 4,
  parameter int OTHER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_isSub,
  output logic [1:0]  alu_ctrl,
  output logic [1:0]  alu_cmp_ctrl,
  input  logic [31:0] alu_result,
  output logic        busy
);

  localparam int MAX_CYCLES = (MUL_CYCLES > OTHER_CYCLES) ? MUL_CYCLES : OTHER_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD   = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] OTHER_LOAD = CW'(OTHER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic          gnt;
  logic          last_gnt;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          req_hs;
  logic          rsp_hs;
  logic [31:0]   sel_a, sel_b;
  logic [4:0]    sel_op;

  // When both ports contend, the one not served last wins.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) gnt = ~last_gnt;
    else if (req1_valid)          gnt = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !gnt && req0_valid;
  assign req1_ready = (state == IDLE) &&  gnt && req1_valid;
  assign req_hs     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  assign sel_a  = gnt ? req1_a  : req0_a;
  assign sel_b  = gnt ? req1_b  : req0_b;
  assign sel_op = gnt ? req1_op : req0_op;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs)      state_nxt = EXEC;
      EXEC:    if (cnt == '0)   state_nxt = RESP;
      RESP:    if (rsp_hs)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      owner        <= 1'b0;
      last_gnt     <= 1'b1;
      rsp_data     <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_isSub    <= 1'b0;
      alu_ctrl     <= 2'b00;
      alu_cmp_ctrl <= 2'b00;
    end else begin
      if (req_hs) begin
        alu_a        <= sel_a;
        alu_b        <= sel_b;
        alu_ctrl     <= sel_op[4:3];
        alu_isSub    <= sel_op[2];
        alu_cmp_ctrl <= sel_op[1:0];
        owner        <= gnt;
        last_gnt     <= gnt;
        cnt          <= (sel_op[4:3] == 2'b11) ? MUL_LOAD : OTHER_LOAD;
      end
      if (state == EXEC) begin
        if (cnt != '0) cnt      <= cnt - CW'(1);
        else           rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU attached to its ALU port.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp_data, alu_a, alu_b, alu_result;
  logic        alu_isSub, busy;
  logic [1:0]  alu_ctrl, alu_cmp_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.MUL_CYCLES(4), .OTHER_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_isSub(alu_isSub),
    .alu_ctrl(alu_ctrl), .alu_cmp_ctrl(alu_cmp_ctrl),
    .alu_result(alu_result), .busy(busy)
  );

  // Behavioural ALU: 00 pass, 01 compare, 10 add/sub, 11 multiply.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      2'b00: alu_result = alu_a;
      2'b01: case (alu_cmp_ctrl)
               2'b00:   alu_result = {31'b0, alu_a == alu_b};
               2'b01:   alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
               2'b10:   alu_result = {31'b0, alu_a < alu_b};
               default: alu_result = {31'b0, alu_a != alu_b};
             endcase
      2'b10: alu_result = alu_isSub ? (alu_a - alu_b) : (alu_a + alu_b);
      default: alu_result = alu_a * alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rvld(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for ready, completes the handshake edge.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    int n;
    if (p == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin
      tick();
      n++;
    end
    check("req_ready", {31'b0, rdy(p)}, 32'd1);
    tick();
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Called in cycle T+1; walks the L EXEC cycles, the response cycle and the return to IDLE.
  task automatic finish_op(input int p, input int L, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [1:0] ectrl, input logic esub, input logic [31:0] edata);
    for (int i = 0; i < L; i++) begin
      check("exec_alu_a", alu_a, ea);
      check("exec_alu_b", alu_b, eb);
      check("exec_alu_ctrl", {30'b0, alu_ctrl}, {30'b0, ectrl});
      check("exec_alu_isSub", {31'b0, alu_isSub}, {31'b0, esub});
      check("exec_busy", {31'b0, busy}, 32'd1);
      check("exec_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      tick();
    end
    check("rsp_valid_owner", {31'b0, rvld(p)}, 32'd1);
    check("rsp_valid_other", {31'b0, rvld(1 - p)}, 32'd0);
    check("rsp_data", rsp_data, edata);
    tick();
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_rsp_valid", {31'b0, rvld(p)}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_rsp_valid"}, {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    check({tag, "_req_ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_ctl"}, {27'b0, alu_ctrl, alu_isSub, alu_cmp_ctrl}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single add on port 0: 5 + 3
    issue(0, 32'd5, 32'd3, 5'b10000);
    finish_op(0, 1, 32'd5, 32'd3, 2'b10, 1'b0, 32'd8);

    // Multiply on port 1: 7 * 6 held for four cycles
    issue(1, 32'd7, 32'd6, 5'b11000);
    finish_op(1, 4, 32'd7, 32'd6, 2'b11, 1'b0, 32'd42);

    // Contention: both valid; port 0 adds 1+2, port 1 subtracts 9-4
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 5'b10000;
    req1_a = 32'd9; req1_b = 32'd4; req1_op = 5'b10100;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("cont_exec_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      tick();
      check("cont_rsp0", {31'b0, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_rsp1", {31'b0, rsp1_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("cont_data", rsp_data, (i % 2 == 0) ? 32'd3 : 32'd5);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Response backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    issue(0, 32'd20, 32'd22, 5'b10000);
    req1_a = 32'd100; req1_b = 32'd1; req1_op = 5'b10100; req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
      check("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
      check("bp_rsp_data", rsp_data, 32'd42);
      check("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_final_valid", {31'b0, rsp0_valid}, 32'd1);
    tick();
    check("bp_idle_busy", {31'b0, busy}, 32'd0);
    check("bp_idle_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    finish_op(1, 1, 32'd100, 32'd1, 2'b10, 1'b1, 32'd99);

    // Reset during the second EXEC cycle of a multiply
    issue(0, 32'd3, 32'd5, 5'b11000);
    tick();
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      tick();
    end
    issue(0, 32'hDEADBEEF, 32'd0, 5'b00000);
    finish_op(0, 1, 32'hDEADBEEF, 32'd0, 2'b00, 1'b0, 32'hDEADBEEF);

    // Subtract: 10 - 3
    issue(0, 32'd10, 32'd3, 5'b10100);
    finish_op(0, 1, 32'd10, 32'd3, 2'b10, 1'b1, 32'd7);

    // ALU inputs keep their last values in IDLE
    check("idle_hold_alu_a", alu_a, 32'd10);
    check("idle_hold_isSub", {31'b0, alu_isSub}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Two-port round-robin scheduler that shares one combinational ALU (pass-through, comparator, add/subtract, multiply) between two requesters. It accepts one operation at a time through a valid/ready handshake and drives registered operands and controls into the ALU. For multiply it holds those inputs stable for a programmable number of cycles, then captures the result and returns it on the requester's own response channel. It sits between the core's issue logic (or a DMA/test master) and the ALU instance.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: cycles the ALU inputs are held for a multiply. Must be at least 1.
- `OTHER_CYCLES`, default 1: cycles the ALU inputs are held for pass, compare and add/sub. Must be at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / port 1.
- `req0_ready`, `req1_ready`  out  1  scheduler accepts the request on port 0 / port 1.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32  operands.
- `req0_op`, `req1_op`  in  5  operation, encoded as {ALU_Control[1:0], isSub, comparator_control[1:0]}.
- `rsp0_valid`, `rsp1_valid`  out  1  result available for port 0 / port 1.
- `rsp0_ready`, `rsp1_ready`  in  1  requester takes the result.
- `rsp_data`  out  32  captured result, shared by both ports; qualified by the asserted `rspN_valid`.
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_isSub`  out  1  registered add/subtract select to the ALU.
- `alu_ctrl`  out  2  registered ALU_Control to the ALU.
- `alu_cmp_ctrl`  out  2  registered comparator_control to the ALU.
- `alu_result`  in  32  ALU combinational result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE -> EXEC on a request handshake.
  - EXEC -> RESP when `cnt` reaches 0.
  - RESP -> IDLE on the response handshake.
- Arbitration, evaluated in IDLE only:
  - `gnt` = the single valid port if only one is valid.
  - If both are valid, `gnt` = the port other than `last_gnt`.
  - `reqN_ready` = (state == IDLE) & (gnt == N) & `reqN_valid`. The two readys are never high together.
- On a handshake (`reqN_valid` & `reqN_ready`):
  - Register `alu_a`, `alu_b` and the three control fields from port N.
  - `owner` <= N, `last_gnt` <= N.
  - `cnt` <= (op[4:3] == 2'b11) ? MUL_CYCLES-1 : OTHER_CYCLES-1.
  - Go to EXEC.
- EXEC:
  - ALU outputs stay constant.
  - If `cnt` != 0, decrement it.
  - If `cnt` == 0, capture `rsp_data` <= `alu_result` and go to RESP.
- RESP:
  - `rsp<owner>_valid` = 1; the other response valid = 0.
  - `rsp_data` and the ALU outputs are held constant.
  - On `rsp<owner>_ready`, go to IDLE.
  - `rsp_ready` of the non-owner port is ignored.
- ALU outputs keep their last value in IDLE; they are not cleared after an operation.
- The block does no arithmetic of its own. The result width is fixed at 32 bits, and overflow and truncation are whatever the ALU produces.
- Reset values:
  - state = IDLE, `cnt` = 0, `owner` = 0.
  - `last_gnt` = 1, so port 0 wins the first contention.
  - `rsp_data` = 0; `alu_a`, `alu_b`, `alu_isSub`, `alu_ctrl`, `alu_cmp_ctrl` = 0.
  - All `reqN_ready` and `rspN_valid` = 0; `busy` = 0.
- Reset mid-operation: any in-flight operation is discarded and no response is issued. After reset, the scheduler accepts a new request in the first cycle that has a valid request.

## Timing
- Handshake at edge T: EXEC occupies cycles T+1 .. T+L, where L = MUL_CYCLES for multiply and OTHER_CYCLES otherwise.
- The result is captured at the end of cycle T+L. `rspN_valid` is high from cycle T+L+1.
- With `rsp_ready` held high, the response handshake occurs at edge T+L+1 and IDLE is entered at T+L+2.
- Throughput is at most one operation per L+2 cycles. A new request cannot be accepted in the same cycle as a response handshake.
- Requesters must hold valid, operands and op stable until ready. The response valid stays high until its ready is seen.
- Ready signals depend combinationally on the valids and the state. Every other output is registered.

## Test plan
- Single add: port 0, a=5, b=3, op=5'b10000 -> `alu_*` show a=5, b=3, ctrl=10 in EXEC; `rsp0_valid` 2 cycles after the handshake; `rsp_data`=8.
- Multiply latency: port 1, a=7, b=6, op=5'b11000, MUL_CYCLES=4 -> `alu_*` stable for 4 cycles; `rsp1_valid` at cycle T+5; `rsp_data`=42.
- Contention: both valid continuously for 4 operations -> grants go 0,1,0,1 and each response is routed to the correct port.
- Response backpressure: `rsp0_ready` held low for 5 cycles -> `rsp0_valid` and `rsp_data` stable and `req1_ready` stays 0 throughout; the handshake on the 6th cycle returns the scheduler to IDLE.
- Reset mid-multiply: `rst_n` asserted in the 2nd EXEC cycle -> all outputs return to their reset values immediately with no response issued; after release, a port 0 pass op (a=0xDEADBEEF, op=5'b00000) returns 0xDEADBEEF.
- Subtract: a=10, b=3, op=5'b10100 -> `alu_isSub`=1 and `rsp_data`=7.
